seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 89 ++++++++
 tb/tb_seg_scan_driver.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a per-frame value snapshot.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic        clkDisplay,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        displayHiLo,
  output logic [3:0]  bitSel,
  output logic [6:0]  segSel
);

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] prescaler;
  logic [1:0]  index;
  logic [15:0] snapshot;

  logic        tick;
  logic        frame_start;
  logic [1:0]  next_index;
  logic [15:0] next_snapshot;
  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  next_seg;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'b1000000;
      4'h1: hex_font = 7'b1111001;
      4'h2: hex_font = 7'b0100100;
      4'h3: hex_font = 7'b0110000;
      4'h4: hex_font = 7'b0011001;
      4'h5: hex_font = 7'b0010010;
      4'h6: hex_font = 7'b0000010;
      4'h7: hex_font = 7'b1111000;
      4'h8: hex_font = 7'b0000000;
      4'h9: hex_font = 7'b0010000;
      4'hA: hex_font = 7'b0001000;
      4'hB: hex_font = 7'b0000011;
      4'hC: hex_font = 7'b1000110;
      4'hD: hex_font = 7'b0100001;
      4'hE: hex_font = 7'b0000110;
      default: hex_font = 7'b0001110;
    endcase
  endfunction

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    tick        = (prescaler == CNT_MAX);
    frame_start = tick && (index == 2'd3);
    next_index  = index + 2'd1;
    // Digit 0 of a new frame must come from the halfword being latched now.
    next_snapshot = snapshot;
    if (frame_start) next_snapshot = displayHiLo ? value[31:16] : value[15:0];
    nibble = 4'(next_snapshot >> {next_index, 2'b00});
    blank  = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    case (next_index)
      2'd3:    blank = (next_snapshot[15:12] == 4'h0);
      2'd2:    blank = (next_snapshot[15:8]  == 8'h00);
      2'd1:    blank = (next_snapshot[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
`endif
    next_seg = blank ? 7'b1111111 : hex_font(nibble);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clkDisplay or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      index     <= 2'd3;
      snapshot  <= '0;
      bitSel    <= 4'b1111;
      segSel    <= 7'b1111111;
    end else begin
      prescaler <= tick ? 16'd0 : prescaler + 16'd1;
      if (tick) begin
        index    <= next_index;
        snapshot <= next_snapshot;
        bitSel   <= ~(4'b0001 << next_index);
        segSel   <= next_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at SCAN_DIV=4; expectations follow
// SEG_SCAN_LEADING_ZERO_BLANK_EN when that macro is defined for the build.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value;
  logic        hilo;
  logic [3:0]  bit_sel;
  logic [6:0]  seg_sel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string           name;
    logic [31:0]     value;
    logic            hilo;
    logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[8];
  logic [3:0] bsel_exp[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seg_scan_driver #(.SCAN_DIV(4)) dut (
    .clkDisplay (clk),
    .reset      (rst_n),
    .value      (value),
    .displayHiLo(hilo),
    .bitSel     (bit_sel),
    .segSel     (seg_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got bitSel/segSel %b_%b, want %b_%b",
               name, act[10:7], act[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic step_expect(input string name, input logic [3:0] b, input logic [6:0] s);
    @(posedge clk);
    #1;
    check(name, {bit_sel, seg_sel}, {b, s});
  endtask

  task automatic check_frame(input string name, input logic [3:0][6:0] seg);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++)
        step_expect($sformatf("%s d%0d c%0d", name, d, c), bsel_exp[d], seg[d]);
  endtask

  task automatic blank_after_release(input string name);
    check({name, " release"}, {bit_sel, seg_sel}, 11'h7FF);
    for (int c = 0; c < 3; c++)
      step_expect($sformatf("%s blank %0d", name, c), 4'b1111, 7'b1111111);
  endtask

  initial begin
    vecs[0] = '{"v1234",    32'h0000_1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{"vA8F0hi",  32'hA8F0_0000, 1'b1, {7'h08, 7'h00, 7'h0E, 7'h40}};
    vecs[2] = '{"v5678",    32'h0000_5678, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[3] = '{"v9BCDhi",  32'h9BCD_EF00, 1'b1, {7'h10, 7'h03, 7'h46, 7'h21}};
    vecs[4] = '{"vEF00lo",  32'h9BCD_EF00, 1'b0, {7'h06, 7'h0E, 7'h40, 7'h40}};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    vecs[5] = '{"vzero",    32'h0000_0000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[6] = '{"v0010",    32'h0000_0010, 1'b0, {7'h7F, 7'h7F, 7'h79, 7'h40}};
    vecs[7] = '{"v0100",    32'hFFFF_0100, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}};
`else
    vecs[5] = '{"vzero",    32'h0000_0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[6] = '{"v0010",    32'h0000_0010, 1'b0, {7'h40, 7'h40, 7'h79, 7'h40}};
    vecs[7] = '{"v0100",    32'hFFFF_0100, 1'b0, {7'h40, 7'h79, 7'h40, 7'h40}};
`endif

    rst_n = 1'b0;
    value = vecs[0].value;
    hilo  = vecs[0].hilo;
    repeat (10) @(posedge clk);
    #1;
    check("in reset", {bit_sel, seg_sel}, 11'h7FF);
    rst_n = 1'b1;
    blank_after_release("first");

    // Inputs are set in the tick cycle of the previous frame, so each frame shows its own vector.
    for (int i = 0; i < 8; i++) begin
      value = vecs[i].value;
      hilo  = vecs[i].hilo;
      check_frame(vecs[i].name, vecs[i].seg);
    end

    // Mid-frame change: 0x1111 frame must finish as "1", then next frame shows "8".
    value = 32'h0000_1111;
    hilo  = 1'b0;
    for (int c = 0; c < 4; c++) step_expect("mid d0", 4'b1110, 7'h79);
    step_expect("mid d1 c0", 4'b1101, 7'h79);
    value = 32'h0000_8888;
    for (int c = 0; c < 3; c++) step_expect("mid d1", 4'b1101, 7'h79);
    for (int c = 0; c < 4; c++) step_expect("mid d2", 4'b1011, 7'h79);
    for (int c = 0; c < 4; c++) step_expect("mid d3", 4'b0111, 7'h79);
    check_frame("after mid", {7'h00, 7'h00, 7'h00, 7'h00});

    // Reset during digit 2: outputs blank without a clock edge, then a clean restart.
    value = 32'h0000_1234;
    for (int c = 0; c < 4; c++) step_expect("rst d0", 4'b1110, 7'h19);
    for (int c = 0; c < 4; c++) step_expect("rst d1", 4'b1101, 7'h30);
    for (int c = 0; c < 2; c++) step_expect("rst d2", 4'b1011, 7'h24);
    #1 rst_n = 1'b0;
    #1 check("async reset", {bit_sel, seg_sel}, 11'h7FF);
    repeat (3) @(posedge clk);
    #1 check("held reset", {bit_sel, seg_sel}, 11'h7FF);
    rst_n = 1'b1;
    blank_after_release("restart");
    check_frame("restart", vecs[0].seg);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
